// File: rtl/tdm_mux_8to1.sv
// Transmit side of the 8-channel serial link: serialises eight 1-bit channels onto one line with a matching slot select.
// Optional even-parity ninth slot enabled by defining TDM_MUX_PARITY_EN.
module tdm_mux_8to1 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       start,
    input  logic       en,
    output logic       out,
    output logic [2:0] sel,
    output logic       valid,
    output logic       frame_start,
    output logic       done,
    output logic       busy,
    output logic       par_slot
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

`ifdef TDM_MUX_PARITY_EN
    localparam logic [3:0] LAST_SLOT = 4'd8;
`else
    localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // Slot 8 only exists in the parity build and carries the parity of the frame.
    function automatic logic slot_bit(input logic [7:0] d, input logic [3:0] k);
        if (k == 4'd8) begin
            return even_parity(d);
        end else begin
            return d[k[2:0]];
        end
    endfunction

    function automatic logic [2:0] slot_sel(input logic [3:0] k);
        if (k == 4'd8) begin
            return 3'd7;
        end else begin
            return k[2:0];
        end
    endfunction

    logic [0:0] state_r, state_s;
    logic [7:0] shadow_r, shadow_s;
    logic [3:0] cnt_r, cnt_s;
    logic       pend_r, pend_s;
    logic       out_r, out_s;
    logic [2:0] sel_r, sel_s;
    logic       valid_r, valid_s;
    logic       fs_r, fs_s;
    logic       done_r, done_s;
    logic       par_r, par_s;
    logic       present_s;
    logic [3:0] slot_s;
    logic [7:0] src_s;

    // Next-state and next-output logic; cnt is the slot currently shown, pend marks slot 0 not yet shown.
    always_comb begin
        state_s   = state_r;
        shadow_s  = shadow_r;
        cnt_s     = cnt_r;
        pend_s    = pend_r;
        out_s     = out_r;
        sel_s     = sel_r;
        valid_s   = 1'b0;
        fs_s      = 1'b0;
        done_s    = 1'b0;
        par_s     = par_r;
        present_s = 1'b0;
        slot_s    = cnt_r;
        src_s     = shadow_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SCAN;
                    shadow_s = in_data;
                    cnt_s    = 4'd0;
                    pend_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_s = ST_SCAN;
                end else if (pend_r) begin
                    present_s = 1'b1;
                    slot_s    = cnt_r;
                    pend_s    = 1'b0;
                end else if (cnt_r == LAST_SLOT) begin
                    if (start) begin
                        // Back-to-back frame: the new data goes straight to the line.
                        shadow_s  = in_data;
                        src_s     = in_data;
                        cnt_s     = 4'd0;
                        slot_s    = 4'd0;
                        present_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 4'd0;
                        out_s   = 1'b0;
                        sel_s   = 3'd0;
                        par_s   = 1'b0;
                    end
                end else begin
                    cnt_s     = cnt_r + 4'd1;
                    slot_s    = cnt_r + 4'd1;
                    present_s = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                pend_s  = 1'b0;
                out_s   = 1'b0;
                sel_s   = 3'd0;
                par_s   = 1'b0;
            end
        endcase
        if (present_s) begin
            out_s   = slot_bit(src_s, slot_s);
            sel_s   = slot_sel(slot_s);
            valid_s = 1'b1;
            fs_s    = (slot_s == 4'd0);
            done_s  = (slot_s == LAST_SLOT);
`ifdef TDM_MUX_PARITY_EN
            par_s   = (slot_s == 4'd8);
`endif
        end else begin
            valid_s = 1'b0;
        end
`ifndef TDM_MUX_PARITY_EN
        par_s = 1'b0;
`endif
    end

    // State, shadow and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            shadow_r <= 8'd0;
            cnt_r    <= 4'd0;
            pend_r   <= 1'b0;
            out_r    <= 1'b0;
            sel_r    <= 3'd0;
            valid_r  <= 1'b0;
            fs_r     <= 1'b0;
            done_r   <= 1'b0;
            par_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            shadow_r <= shadow_s;
            cnt_r    <= cnt_s;
            pend_r   <= pend_s;
            out_r    <= out_s;
            sel_r    <= sel_s;
            valid_r  <= valid_s;
            fs_r     <= fs_s;
            done_r   <= done_s;
            par_r    <= par_s;
        end
    end

    assign out         = out_r;
    assign sel         = sel_r;
    assign valid       = valid_r;
    assign frame_start = fs_r;
    assign done        = done_r;
    assign busy        = (state_r == ST_SCAN);
    assign par_slot    = par_r;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Directed self-checking bench for tdm_mux_8to1; honours TDM_MUX_PARITY_EN when defined.
module tb_tdm_mux_8to1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       out;
    logic [2:0] sel;
    logic       valid;
    logic       frame_start;
    logic       done;
    logic       busy;
    logic       par_slot;

    int n_pass = 0;
    int n_total = 0;

`ifdef TDM_MUX_PARITY_EN
    localparam int LAST = 8;
`else
    localparam int LAST = 7;
`endif

    tdm_mux_8to1 dut (
        .clk(clk), .rst(rst), .in_data(in_data), .start(start), .en(en),
        .out(out), .sel(sel), .valid(valid), .frame_start(frame_start),
        .done(done), .busy(busy), .par_slot(par_slot)
    );

    always #5 clk = ~clk;

    // {busy, out, sel, valid, frame_start, done, par_slot}
    logic [8:0] obs;
    assign obs = {busy, out, sel, valid, frame_start, done, par_slot};

    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 8) return ^d;
        return d[k];
    endfunction

    function automatic logic [2:0] exp_sel(input int k);
        logic [3:0] kk;
        kk = k[3:0];
        if (k == 8) return 3'd7;
        return kk[2:0];
    endfunction

    function automatic logic [8:0] exp_slot(input logic [7:0] d, input int k);
        return {1'b1, exp_bit(d, k), exp_sel(k), 1'b1, (k == 0), (k == LAST), (k == 8)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_data = 8'hFF; en = 1'b1;
        tick();
        tick();
        rst = 1'b0; start = 1'b0;
        n_total++;
        if (obs !== 9'd0) $display("FAIL reset outputs got %b want %b", obs, 9'd0);
        else n_pass++;
    endtask

    task automatic test_frame();
        logic [7:0] d = 8'hA6;
        in_data = d; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        n_total++;
        if (obs !== 9'b1_0_000_0_0_0_0) $display("FAIL frame accept got %b want %b", obs, 9'b1_0_000_0_0_0_0);
        else n_pass++;
        for (int k = 0; k <= LAST; k++) begin
            tick();
            n_total++;
            if (obs !== exp_slot(d, k)) $display("FAIL frame slot%0d got %b want %b", k, obs, exp_slot(d, k));
            else n_pass++;
        end
        tick();
        n_total++;
        if (obs !== 9'd0) $display("FAIL frame idle got %b want %b", obs, 9'd0);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] d = 8'hFF;
        in_data = d; start = 1'b1; en = 1'b0;
        tick();
        start = 1'b0;
        tick();
        n_total++;
        if (obs !== 9'b1_0_000_0_0_0_0) $display("FAIL stall first_wait got %b want %b", obs, 9'b1_0_000_0_0_0_0);
        else n_pass++;
        en = 1'b1;
        for (int k = 0; k <= LAST; k++) begin
            tick();
            n_total++;
            if (obs !== exp_slot(d, k)) $display("FAIL stall slot%0d got %b want %b", k, obs, exp_slot(d, k));
            else n_pass++;
            if (k == 3) begin
                en = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    tick();
                    n_total++;
                    if (obs !== 9'b1_1_011_0_0_0_0) $display("FAIL stall hold%0d got %b want %b", s, obs, 9'b1_1_011_0_0_0_0);
                    else n_pass++;
                end
                en = 1'b1;
            end
        end
        tick();
        n_total++;
        if (obs !== 9'd0) $display("FAIL stall idle got %b want %b", obs, 9'd0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1 = 8'h0F;
        logic [7:0] d2 = 8'hF0;
        in_data = d1; start = 1'b1; en = 1'b1;
        tick();
        for (int k = 0; k <= LAST; k++) begin
            tick();
            n_total++;
            if (obs !== exp_slot(d1, k)) $display("FAIL b2b f1 slot%0d got %b want %b", k, obs, exp_slot(d1, k));
            else n_pass++;
            if (k == 3) in_data = d2;
        end
        for (int k = 0; k <= LAST; k++) begin
            tick();
            n_total++;
            if (obs !== exp_slot(d2, k)) $display("FAIL b2b f2 slot%0d got %b want %b", k, obs, exp_slot(d2, k));
            else n_pass++;
            start = 1'b0;
        end
        tick();
        n_total++;
        if (obs !== 9'd0) $display("FAIL b2b idle got %b want %b", obs, 9'd0);
        else n_pass++;
    endtask

    task automatic test_abort();
        in_data = 8'hA6; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 4; k++) tick();
        n_total++;
        if (obs !== exp_slot(8'hA6, 4)) $display("FAIL abort slot4 got %b want %b", obs, exp_slot(8'hA6, 4));
        else n_pass++;
        rst = 1'b1; start = 1'b1;
        tick();
        n_total++;
        if (obs !== 9'd0) $display("FAIL abort clear got %b want %b", obs, 9'd0);
        else n_pass++;
        rst = 1'b0; start = 1'b0;
        tick();
        n_total++;
        if (obs !== 9'd0) $display("FAIL abort start_ignored got %b want %b", obs, 9'd0);
        else n_pass++;
        in_data = 8'h5B; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_total++;
        if (obs !== exp_slot(8'h5B, 0)) $display("FAIL abort restart got %b want %b", obs, exp_slot(8'h5B, 0));
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_start_ignored();
        logic [7:0] d = 8'h3C;
        in_data = d; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= LAST; k++) begin
            tick();
            n_total++;
            if (obs !== exp_slot(d, k)) $display("FAIL ignore slot%0d got %b want %b", k, obs, exp_slot(d, k));
            else n_pass++;
            if (k == 2) begin
                start = 1'b1; in_data = 8'hC3;
            end else begin
                start = 1'b0;
            end
        end
        tick();
        n_total++;
        if (obs !== 9'd0) $display("FAIL ignore idle got %b want %b", obs, 9'd0);
        else n_pass++;
    endtask

`ifdef TDM_MUX_PARITY_EN
    task automatic test_parity();
        in_data = 8'hA7; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 8; k++) tick();
        n_total++;
        if (obs !== 9'b1_1_111_1_0_1_1) $display("FAIL parity A7 got %b want %b", obs, 9'b1_1_111_1_0_1_1);
        else n_pass++;
        tick();
        in_data = 8'hA6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 8; k++) tick();
        n_total++;
        if (obs !== 9'b1_0_111_1_0_1_1) $display("FAIL parity A6 got %b want %b", obs, 9'b1_0_111_1_0_1_1);
        else n_pass++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_stall();
        test_back_to_back();
        test_abort();
        test_start_ignored();
`ifdef TDM_MUX_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tdm_mux_8to1.md
# tdm_mux_8to1

Time-division 8-to-1 multiplexer that serialises eight 1-bit channels onto one line, one channel per clock slot. It drives the matching 3-bit slot select alongside each bit, so a 1-to-8 demultiplexer on the far end can route each bit back to its channel. It is the transmit side of the 8-channel serial link; the existing demux is the receive side.

## Interface
- No parameters: channel count is fixed at 8 and select width at 3.
- `clk` input 1: single clock; every flop updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: channel bits; bit i is channel i. Sampled only when a frame is accepted.
- `start` input 1: frame request; sampled at the rising edge.
- `en` input 1: slot-advance enable. When 0, the frame stalls.
- `out` output 1: serial data bit for the current slot.
- `sel` output 3: channel index of the bit on `out`; drives the demux select.
- `valid` output 1: `out`/`sel` carry a live slot this cycle.
- `frame_start` output 1: high during slot 0 of each frame.
- `done` output 1: high during the final slot of each frame.
- `busy` output 1: a frame is in progress (state SCAN).
- `par_slot` output 1: current slot is the parity slot (see Configuration).

## Operation
- States: IDLE and SCAN. Shadow register `shadow[7:0]`, slot counter `cnt`.
- IDLE, `start`=1 at an edge:
  - `shadow` <= `in_data`, `cnt` <= 0, state <= SCAN.
- SCAN, each edge with `en`=1:
  - Slot k presents `out`=`shadow[k]`, `sel`=k, `valid`=1.
  - `frame_start`=1 when k=0; `done`=1 when k is the last slot.
- SCAN, `en`=0:
  - `cnt`, `sel` and `out` hold their values; `valid`, `frame_start` and `done` are 0.
  - Channel order is never disturbed by a stall.
- Last slot with `en`=1:
  - If `start`=1 at that edge: reload `shadow` from `in_data`; the next cycle is slot 0 of the new frame (back-to-back, no gap).
  - Otherwise return to IDLE.
- `start` is ignored in SCAN except in the last-slot cycle.
- Changes on `in_data` after acceptance do not affect the frame in flight.
- IDLE outputs: `out`=0, `sel`=0, `valid`=0, `frame_start`=0, `done`=0, `busy`=0, `par_slot`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: `out`=0, `sel`=3'b000, `valid`=0, `frame_start`=0, `done`=0, `busy`=0, `par_slot`=0. Also `shadow`=0, `cnt`=0, state IDLE.
- Latency: `start` sampled at edge N puts slot 0 on the outputs after edge N+1. `busy` rises after edge N.
- Frame length with `en` held at 1: 8 cycles, or 9 with parity. Each `en`=0 cycle adds one cycle.
- `sel` wraps 7 -> 0 only on a back-to-back frame; otherwise `sel` returns to 0 with IDLE.
- `rst`=1 mid-frame: at the next edge, abort and clear to reset values. `start` in the same cycle as `rst` is ignored.
- `en` is ignored in IDLE. The first slot waits for `en`=1.

## Configuration
- Macro: `TDM_MUX_PARITY_EN`.
- Defined:
  - A ninth slot follows slot 7, carrying `out` = XOR of `shadow[7:0]` (even parity).
  - That slot has `sel`=3'b111, `valid`=1, `par_slot`=1.
  - `done` moves to the parity slot; slot 7 no longer asserts `done`.
- Undefined: 8-slot frame, and `par_slot` is constant 0.

## Test plan
- Reset, then `in_data`=8'hA6, `start` pulse, `en`=1 -> `out` over slots 0..7 = 0,1,1,0,0,1,0,1; `sel` = 0..7; `frame_start` only in slot 0; `done` only in slot 7; IDLE the next cycle.
- `in_data`=8'hFF, then `en`=0 for 2 cycles during slot 3 -> `sel`=3 and `out`=1 hold with `valid`=0; the frame completes in 10 cycles.
- `start` held high throughout, first `in_data`=8'h0F, changed to 8'hF0 mid-frame -> frame 1 = 1,1,1,1,0,0,0,0; frame 2 = 0,0,0,0,1,1,1,1 immediately after; `sel` wraps 7 -> 0 with no gap.
- `rst`=1 during slot 4 -> every output is 0 at the next edge; a new `start` then begins again at slot 0.
- `TDM_MUX_PARITY_EN` defined, `in_data`=8'hA7 -> slot 8 has `out`=1, `sel`=7, `par_slot`=1, `done`=1. With 8'hA6 -> `out`=0.
- `start` pulsed in SCAN outside the last slot, with `in_data` changed -> ignored; the frame data is unchanged.
